// File: rtl/uid_cmd_engine.sv
// Byte-stream command engine: assembles command frames from UART bytes and runs
// check/add/delete/clear against a UID table, returning one status byte per frame.
module uid_cmd_engine #(
  parameter int unsigned UID_BYTES      = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   rep_data,
  output logic                         rep_valid,
  input  logic                         rep_ready,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   entry_count,
  output logic                         drop_pulse
);

  localparam int unsigned UID_W = UID_BYTES * 8;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned BW    = $clog2(UID_BYTES) + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_CHECK  = 8'hA1;
  localparam logic [7:0] CMD_ADD    = 8'hB2;
  localparam logic [7:0] CMD_DELETE = 8'hC3;
  localparam logic [7:0] CMD_CLEAR  = 8'hD4;

  typedef enum logic [2:0] {IDLE, RX_UID, SEARCH, EXEC, REPLY} state_t;

  state_t             state, state_nxt;
  logic [7:0]         cmd;
  logic [UID_W-1:0]   uid;
  logic [BW-1:0]      bcnt;
  logic [TW-1:0]      tcnt;
  logic [IW-1:0]      idx;
  logic               hit, free_found;
  logic [IW-1:0]      hit_idx, free_idx;
  logic [7:0]         rep_reg;
  logic [DEPTH-1:0]   valid;
  logic [UID_W-1:0]   uid_mem [DEPTH];

  logic last_byte, timed_out, known_uid_cmd, add_ok;

  assign last_byte     = rx_valid && (bcnt == BW'(UID_BYTES - 1));
  assign timed_out     = !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign known_uid_cmd = (rx_data == CMD_CHECK) || (rx_data == CMD_ADD) || (rx_data == CMD_DELETE);
  assign add_ok        = (cmd == CMD_ADD) && !hit && free_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_valid) begin
        if (known_uid_cmd)           state_nxt = RX_UID;
        else if (rx_data == CMD_CLEAR) state_nxt = EXEC;
        else                         state_nxt = REPLY;
      end
      RX_UID: begin
        if (last_byte)      state_nxt = SEARCH;
        else if (timed_out) state_nxt = REPLY;
      end
      SEARCH:  if (idx == IW'(DEPTH - 1)) state_nxt = EXEC;
      EXEC:    state_nxt = REPLY;
      REPLY:   if (rep_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rep_valid  = (state == REPLY);
    busy       = (state != IDLE);
    drop_pulse = rx_valid && ((state == SEARCH) || (state == EXEC) || (state == REPLY));
    rep_data   = rep_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd         <= '0;
      uid         <= '0;
      bcnt        <= '0;
      tcnt        <= '0;
      idx         <= '0;
      hit         <= 1'b0;
      free_found  <= 1'b0;
      hit_idx     <= '0;
      free_idx    <= '0;
      rep_reg     <= '0;
      valid       <= '0;
      entry_count <= '0;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          cmd  <= rx_data;
          bcnt <= '0;
          tcnt <= '0;
          if (!known_uid_cmd && rx_data != CMD_CLEAR) rep_reg <= 8'hE1;
        end
        RX_UID: begin
          if (rx_valid) begin
            uid  <= (uid << 8) | UID_W'(rx_data);
            bcnt <= bcnt + 1'b1;
            tcnt <= '0;
            if (last_byte) begin
              idx        <= '0;
              hit        <= 1'b0;
              free_found <= 1'b0;
            end
          end else if (timed_out) begin
            rep_reg <= 8'hE0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SEARCH: begin
          // First valid match and lowest invalid slot are both latched during the single pass.
          if (!hit && valid[idx] && uid_mem[idx] == uid) begin
            hit     <= 1'b1;
            hit_idx <= idx;
          end
          if (!free_found && !valid[idx]) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + 1'b1;
        end
        EXEC: begin
          case (cmd)
            CMD_CHECK: rep_reg <= hit ? 8'h01 : 8'h00;
            CMD_ADD: begin
              if (hit)             rep_reg <= 8'hEE;
              else if (free_found) begin
                rep_reg          <= 8'h02;
                valid[free_idx]  <= 1'b1;
                entry_count      <= entry_count + 1'b1;
              end else             rep_reg <= 8'hEF;
            end
            CMD_DELETE: begin
              if (hit) begin
                rep_reg         <= 8'h03;
                valid[hit_idx]  <= 1'b0;
                entry_count     <= entry_count - 1'b1;
              end else rep_reg <= 8'hED;
            end
            default: begin
              rep_reg     <= 8'h04;
              valid       <= '0;
              entry_count <= '0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == EXEC && add_ok) uid_mem[free_idx] <= uid;
  end

endmodule

// File: tb/tb_uid_cmd_engine.sv
// Directed self-checking bench for uid_cmd_engine (UID_BYTES=4, DEPTH=8, short timeout).
module tb_uid_cmd_engine;
  localparam int unsigned UB = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rep_data;
  logic       rep_valid;
  logic       rep_ready;
  logic       busy;
  logic [$clog2(DP+1)-1:0] entry_count;
  logic       drop_pulse;

  int total = 0;
  int bad   = 0;

  uid_cmd_engine #(.UID_BYTES(UB), .DEPTH(DP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rep_data(rep_data), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .busy(busy), .entry_count(entry_count), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic send_bytes(input logic [7:0] c, input logic [31:0] u, input int nuid);
    @(negedge clk);
    rx_data = c; rx_valid = 1'b1;
    for (int i = 0; i < nuid; i++) begin
      @(negedge clk);
      rx_data = u[31-8*i -: 8];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a frame and waits (bounded) for the reply; lat counts cycles after the last byte strobe.
  task automatic frame(input logic [7:0] c, input logic [31:0] u, input int nuid,
                       output logic [7:0] r, output int lat);
    send_bytes(c, u, nuid);
    lat = 1;
    while (!rep_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    r = rep_valid ? rep_data : 8'hXX;
    if (rep_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rep_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL reset_rep_valid got=%b exp=0", rep_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (entry_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", entry_count); end
    total++; if (rep_data !== 8'h00) begin bad++; $display("FAIL reset_rep_data got=%h exp=00", rep_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_check_empty();
    logic [7:0] r; int lat;
    frame(8'hA1, 32'h11223344, UB, r, lat);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL check_empty_rep got=%h exp=00", r); end
    total++; if (lat != DP + 2) begin bad++; $display("FAIL check_empty_lat got=%0d exp=%0d", lat, DP + 2); end
    total++; if (entry_count !== 0) begin bad++; $display("FAIL check_empty_count got=%0d exp=0", entry_count); end
    total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL rep_valid_drop got=%b exp=0", rep_valid); end
  endtask

  task automatic test_add();
    logic [7:0] r; int lat;
    frame(8'hB2, 32'h11223344, UB, r, lat);
    total++; if (r !== 8'h02) begin bad++; $display("FAIL add_rep got=%h exp=02", r); end
    total++; if (entry_count !== 1) begin bad++; $display("FAIL add_count got=%0d exp=1", entry_count); end
    frame(8'hB2, 32'h11223344, UB, r, lat);
    total++; if (r !== 8'hEE) begin bad++; $display("FAIL add_dup_rep got=%h exp=EE", r); end
    total++; if (entry_count !== 1) begin bad++; $display("FAIL add_dup_count got=%0d exp=1", entry_count); end
    frame(8'hA1, 32'h11223344, UB, r, lat);
    total++; if (r !== 8'h01) begin bad++; $display("FAIL check_hit_rep got=%h exp=01", r); end
  endtask

  task automatic test_full();
    logic [7:0] r; int lat; int add_bad = 0;
    frame(8'hD4, 32'h0, 0, r, lat);
    total++; if (r !== 8'h04) begin bad++; $display("FAIL clear_rep got=%h exp=04", r); end
    total++; if (lat != 2) begin bad++; $display("FAIL clear_lat got=%0d exp=2", lat); end
    for (int i = 0; i < DP; i++) begin
      frame(8'hB2, 32'hA0000000 + i, UB, r, lat);
      if (r !== 8'h02) add_bad++;
    end
    total++; if (add_bad != 0) begin bad++; $display("FAIL fill_adds got=%0d_bad exp=0_bad", add_bad); end
    total++; if (entry_count !== DP) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", entry_count, DP); end
    frame(8'hB2, 32'hA00000FF, UB, r, lat);
    total++; if (r !== 8'hEF) begin bad++; $display("FAIL add_full_rep got=%h exp=EF", r); end
    frame(8'hC3, 32'hA0000003, UB, r, lat);
    total++; if (r !== 8'h03) begin bad++; $display("FAIL delete_rep got=%h exp=03", r); end
    total++; if (entry_count !== DP - 1) begin bad++; $display("FAIL delete_count got=%0d exp=%0d", entry_count, DP - 1); end
    frame(8'hC3, 32'hA0000003, UB, r, lat);
    total++; if (r !== 8'hED) begin bad++; $display("FAIL delete_miss_rep got=%h exp=ED", r); end
    frame(8'hB2, 32'hBEEF0003, UB, r, lat);
    total++; if (r !== 8'h02) begin bad++; $display("FAIL readd_rep got=%h exp=02", r); end
    total++; if (dut.uid_mem[3] !== 32'hBEEF0003) begin bad++; $display("FAIL readd_slot got=%h exp=BEEF0003", dut.uid_mem[3]); end
    total++; if (entry_count !== DP) begin bad++; $display("FAIL readd_count got=%0d exp=%0d", entry_count, DP); end
  endtask

  task automatic test_drop();
    int lat; int drops = 0;
    send_bytes(8'hA1, 32'hA0000005, UB);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hB2; rx_valid = 1'b1;
      #1 if (drop_pulse === 1'b1) drops++;
      @(negedge clk);
      lat++;
    end
    rx_valid = 1'b0;
    while (!rep_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total++; if (drops != 3) begin bad++; $display("FAIL drop_pulses got=%0d exp=3", drops); end
    total++; if (rep_data !== 8'h01) begin bad++; $display("FAIL drop_rep got=%h exp=01", rep_data); end
    total++; if (lat != DP + 2) begin bad++; $display("FAIL drop_lat got=%0d exp=%0d", lat, DP + 2); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_stall();
    logic [7:0] r; int lat; int unstable = 0;
    rep_ready = 1'b0;
    frame(8'h55, 32'h0, 0, r, lat);
    total++; if (r !== 8'hE1) begin bad++; $display("FAIL unknown_rep got=%h exp=E1", r); end
    total++; if (lat != 1) begin bad++; $display("FAIL unknown_lat got=%0d exp=1", lat); end
    repeat (50) begin
      @(negedge clk);
      if (rep_valid !== 1'b1 || rep_data !== 8'hE1) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold got=%0d_unstable exp=0", unstable); end
    rep_ready = 1'b1;
    @(negedge clk);
    total++; if (rep_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", rep_valid); end
  endtask

  task automatic test_timeout();
    logic [7:0] r; int lat;
    send_bytes(8'hA1, 32'h11220000, 2);
    lat = 1;
    while (!rep_valid && lat < TO + 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (rep_data !== 8'hE0 || !rep_valid) begin bad++; $display("FAIL timeout_rep got=%h exp=E0", rep_data); end
    total++; if (lat < TO || lat > TO + 2) begin bad++; $display("FAIL timeout_lat got=%0d exp=%0d", lat, TO + 1); end
    @(negedge clk);
    frame(8'hA1, 32'hBEEF0003, UB, r, lat);
    total++; if (r !== 8'h01) begin bad++; $display("FAIL after_timeout_rep got=%h exp=01", r); end
    total++; if (lat != DP + 2) begin bad++; $display("FAIL after_timeout_lat got=%0d exp=%0d", lat, DP + 2); end
  endtask

  task automatic test_clear();
    logic [7:0] r; int lat;
    frame(8'hD4, 32'h0, 0, r, lat);
    for (int i = 0; i < 5; i++) frame(8'hB2, 32'hC0DE0000 + i, UB, r, lat);
    total++; if (entry_count !== 5) begin bad++; $display("FAIL five_adds_count got=%0d exp=5", entry_count); end
    frame(8'hD4, 32'h0, 0, r, lat);
    total++; if (r !== 8'h04) begin bad++; $display("FAIL clear5_rep got=%h exp=04", r); end
    total++; if (entry_count !== 0) begin bad++; $display("FAIL clear5_count got=%0d exp=0", entry_count); end
    frame(8'hA1, 32'hC0DE0002, UB, r, lat);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL after_clear_check got=%h exp=00", r); end
  endtask

  task automatic test_reset_mid_search();
    logic [7:0] r; int lat; int seen = 0;
    send_bytes(8'hB2, 32'h77777777, UB);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (rep_valid !== 1'b0 || busy !== 1'b0 || drop_pulse !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%b%b%b exp=000", rep_valid, busy, drop_pulse);
    end
    total++; if (entry_count !== 0 || rep_data !== 8'h00) begin
      bad++; $display("FAIL midreset_regs got=%0d/%h exp=0/00", entry_count, rep_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DP + 10) begin
      @(negedge clk);
      if (rep_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_reply got=%0d exp=0", seen); end
    frame(8'hA1, 32'h77777777, UB, r, lat);
    total++; if (r !== 8'h00) begin bad++; $display("FAIL midreset_not_added got=%h exp=00", r); end
  endtask

  initial begin
    test_reset();
    test_check_empty();
    test_add();
    test_full();
    test_drop();
    test_stall();
    test_timeout();
    test_clear();
    test_reset_mid_search();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
